// File: rtl/gfp8_fp16_converter.sv
// GFP8 (signed 32-bit mantissa, signed 8-bit power-of-two exponent) to IEEE binary16.
// Combinational normalise/round ahead of a single output register with a valid qualifier.
module gfp8_fp16_converter (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_gfp_mantissa,
    input  logic [7:0]  i_gfp_exponent,
    input  logic        i_valid,
    output logic [15:0] o_fp16_result,
    output logic        o_valid
);

    function automatic logic [4:0] lead_one(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    function automatic logic rne_up(input logic lsb, input logic guard, input logic sticky);
        return guard & (sticky | lsb);
    endfunction

    logic               w_sign;
    logic        [31:0] w_mag;
    logic        [4:0]  w_lead;
    logic        [31:0] w_norm;
    logic               w_is_zero;
    logic signed [10:0] w_exp_ext;
    logic signed [10:0] w_be;

    logic               w_n_up;
    logic        [10:0] w_n_frac_r;
    logic signed [10:0] w_n_be_r;
    logic               w_n_ovf;

    logic signed [10:0] w_neg_be;
    logic        [5:0]  w_sub_sh;
    logic        [64:0] w_wide;
    logic               w_s_up;
    logic        [10:0] w_s_frac_r;

    logic        [15:0] w_result;
    logic        [15:0] r_fp16_p1;
    logic               r_vld_p1;

    assign w_sign    = i_gfp_mantissa[31];
    assign w_mag     = w_sign ? (32'd0 - i_gfp_mantissa) : i_gfp_mantissa;
    assign w_lead    = lead_one(w_mag);
    // Leading one lands in bit 31; an all-zero magnitude leaves bit 31 clear.
    assign w_norm    = w_mag << (5'd31 - w_lead);
    assign w_is_zero = ~w_norm[31];

    assign w_exp_ext = {{3{i_gfp_exponent[7]}}, i_gfp_exponent};
    assign w_be      = w_exp_ext + $signed({6'b0, w_lead}) + 11'sd15;

    assign w_n_up     = rne_up(w_norm[21], w_norm[20], |w_norm[19:0]);
    assign w_n_frac_r = {1'b0, w_norm[30:21]} + {10'b0, w_n_up};
    assign w_n_be_r   = w_be + $signed({10'b0, w_n_frac_r[10]});
    assign w_n_ovf    = (w_n_be_r >= 11'sd31);

    // Subnormal integer is norm >> (22 - be); the extra 33 zero bits keep every
    // shifted-out bit available for guard and sticky.
    assign w_neg_be   = 11'sd0 - w_be;
    assign w_sub_sh   = (w_neg_be > 11'sd33) ? 6'd33 : w_neg_be[5:0];
    assign w_wide     = {w_norm, 33'b0} >> w_sub_sh;
    assign w_s_up     = rne_up(w_wide[55], w_wide[54], |w_wide[53:0]);
    assign w_s_frac_r = {1'b0, w_wide[64:55]} + {10'b0, w_s_up};

    always_comb begin
        w_result = 16'h0000;
        if (w_is_zero) begin
            w_result = 16'h0000;
        end else if (w_be <= 11'sd0) begin
            // A rounded value of 1024 spills naturally into the smallest normal.
            w_result = {w_sign, 4'b0000, w_s_frac_r};
        end else if (w_n_ovf) begin
            w_result = {w_sign, 5'h1F, 10'h000};
        end else begin
            w_result = {w_sign, w_n_be_r[4:0], w_n_frac_r[9:0]};
        end
    end

    // Stage p1: output register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fp16_p1 <= 16'h0000;
            r_vld_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= i_valid;
            if (i_valid) r_fp16_p1 <= w_result;
        end
    end

    assign o_fp16_result = r_fp16_p1;
    assign o_valid       = r_vld_p1;

endmodule

// File: tb/tb_gfp8_fp16_converter.sv
// Scoreboard bench for gfp8_fp16_converter: directed values plus random traffic
// checked against a real-arithmetic binary16 rounding model.
module tb_gfp8_fp16_converter;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] i_gfp_mantissa;
    logic [7:0]  i_gfp_exponent;
    logic        i_valid;
    logic [15:0] o_fp16_result;
    logic        o_valid;

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    logic [15:0] exp_q[$];
    int          cyc_q[$];
    logic [15:0] last_res = 16'h0000;

    gfp8_fp16_converter dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_gfp_mantissa (i_gfp_mantissa),
        .i_gfp_exponent (i_gfp_exponent),
        .i_valid        (i_valid),
        .o_fp16_result  (o_fp16_result),
        .o_valid        (o_valid)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cycle++;

    function automatic real pow2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else repeat (-k) r = r / 2.0;
        return r;
    endfunction

    function automatic int rne(input real q);
        real fl, d;
        int  n;
        fl = $floor(q);
        d  = q - fl;
        n  = $rtoi(fl);
        if (d > 0.5 || (d == 0.5 && (n % 2) == 1)) n = n + 1;
        return n;
    endfunction

    // Value = M * 2^X exactly in double precision, then rounded to binary16.
    function automatic logic [15:0] ref_fp16(input logic [31:0] m, input logic [7:0] x);
        longint mg;
        real    a;
        int     e, n;
        logic   s;
        s  = m[31];
        mg = longint'($signed(m));
        if (mg < 0) mg = -mg;
        if (mg == 0) return 16'h0000;
        a = real'(mg) * pow2(int'($signed(x)));
        if (a >= 65520.0) return {s, 5'h1F, 10'h000};
        if (a < pow2(-14)) begin
            n = rne(a * pow2(24));
            return {s, 15'(n)};
        end
        e = -14;
        for (int k = -14; k <= 15; k++) begin
            if (a >= pow2(k)) e = k;
        end
        n = rne(a * pow2(10 - e));
        if (n == 2048) begin
            e = e + 1;
            n = 1024;
        end
        return {s, 5'(e + 15), 10'(n - 1024)};
    endfunction

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, want, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, want, $time);
        end
    endtask

    task automatic issue_exp(input logic [31:0] m, input logic [7:0] x, input logic [15:0] want);
        @(negedge i_clk);
        i_gfp_mantissa = m;
        i_gfp_exponent = x;
        i_valid        = 1'b1;
        exp_q.push_back(want);
        cyc_q.push_back(cycle);
    endtask

    task automatic issue_rand();
        logic [31:0] m;
        logic [7:0]  x;
        case ($urandom_range(0, 4))
            0: m = $urandom;
            1: m = 32'($urandom_range(0, 4095));
            2: m = 32'd0 - 32'($urandom_range(1, 4095));
            3: m = $urandom >> $urandom_range(0, 31);
            default: m = {1'b1, 31'($urandom)};
        endcase
        if ($urandom_range(0, 3) == 0) x = 8'($urandom);
        else x = 8'($urandom_range(0, 60) - 45);
        issue_exp(m, x, ref_fp16(m, x));
    endtask

    task automatic idle();
        @(negedge i_clk);
        i_valid        = 1'b0;
        i_gfp_mantissa = $urandom;
        i_gfp_exponent = 8'($urandom);
    endtask

    task automatic drain();
        int budget;
        budget = 10;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge i_clk);
            #2;
            budget--;
        end
        chk_int("drain_pending", exp_q.size(), 0);
    endtask

    always @(posedge i_clk) begin
        logic [15:0] e;
        int          c;
        #1;
        if (i_reset) begin
            last_res = 16'h0000;
        end else if (o_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid got=%h want=none t=%0t", o_fp16_result, $time);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                chk16("result", o_fp16_result, e);
                chk_int("latency", cycle, c + 1);
                last_res = e;
            end
        end else begin
            chk16("hold", o_fp16_result, last_res);
        end
    end

    initial begin
        i_reset        = 1'b1;
        i_valid        = 1'b0;
        i_gfp_mantissa = 32'd0;
        i_gfp_exponent = 8'd0;
        #3;
        chk16("reset_result", o_fp16_result, 16'h0000);
        chk_int("reset_valid", int'(o_valid), 0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;

        issue_exp(32'd1,          8'd0,    16'h3C00);
        issue_exp(-32'sd3,        -8'sd1,  16'hBE00);
        issue_exp(32'd0,          8'd5,    16'h0000);
        issue_exp(32'h80000000,   -8'sd31, 16'hBC00);
        issue_exp(32'd2049,       8'd0,    16'h6800);
        issue_exp(32'd2051,       8'd0,    16'h6802);
        issue_exp(32'd2047,       8'd5,    16'h7BFF);
        issue_exp(32'd4095,       8'd4,    16'h7C00);
        issue_exp(32'd1,          8'd16,   16'h7C00);
        issue_exp(-32'sd1,        8'd127,  16'hFC00);
        issue_exp(32'h7FFFFFFF,   8'h80,   16'h0000);
        issue_exp(32'd1,          -8'sd24, 16'h0001);
        issue_exp(32'd1,          -8'sd25, 16'h0000);
        issue_exp(32'd3,          -8'sd25, 16'h0002);
        issue_exp(-32'sd1,        -8'sd26, 16'h8000);
        issue_exp(32'd2047,       -8'sd25, 16'h0400);
        idle();

        issue_exp(32'd1, 8'd0, 16'h3C00);
        issue_exp(32'd2, 8'd0, 16'h4000);
        issue_exp(32'd4, 8'd0, 16'h4400);
        idle();
        @(posedge i_clk);
        #2;
        chk_int("stream_drop_valid", int'(o_valid), 0);
        chk16("stream_hold", o_fp16_result, 16'h4400);
        repeat (2) idle();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) issue_rand();
            else idle();
        end
        idle();
        drain();

        issue_exp(32'd1, 8'd0, 16'h3C00);
        idle();
        chk_int("pre_reset_valid", int'(o_valid), 1);
        #1;
        i_reset = 1'b1;
        #1;
        chk_int("async_reset_valid", int'(o_valid), 0);
        chk16("async_reset_result", o_fp16_result, 16'h0000);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        issue_exp(-32'sd3, -8'sd1, 16'hBE00);
        issue_exp(32'd3,   -8'sd25, 16'h0002);
        idle();
        drain();
        repeat (2) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
